// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle MIPS control FSM and its datapath.
// The master side is the FSM; the slave side is the datapath, memory and register file.
interface multicycle_control_if;
   logic [5:0] opcode;
   logic       zero;
   logic       jreg;
   logic       pc_en;
   logic [1:0] pc_src;
   logic       ir_write;
   logic       mem_read;
   logic       mem_write;
   logic       i_or_d;
   logic       reg_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic       zero_ext;
   logic [2:0] alu_op;
   logic       done;
   logic       illegal_op;
   logic [3:0] state;

   modport master (
      input  opcode, zero, jreg,
      output pc_en, pc_src, ir_write, mem_read, mem_write, i_or_d,
             reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
             zero_ext, alu_op, done, illegal_op, state
   );

   modport slave (
      output opcode, zero, jreg,
      input  pc_en, pc_src, ir_write, mem_read, mem_write, i_or_d,
             reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
             zero_ext, alu_op, done, illegal_op, state
   );
endinterface

// File: rtl/multicycle_control.sv
// Main sequencing FSM of the multi-cycle MIPS core: fetch, decode, execute,
// memory and write-back steps with Moore outputs decoded from the current state.
module multicycle_control (
   input logic                  clk,
   input logic                  rst,
   multicycle_control_if.master bus
);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_FETCH     = 4'd1;
   localparam logic [3:0] S_DECODE    = 4'd2;
   localparam logic [3:0] S_MEM_ADDR  = 4'd3;
   localparam logic [3:0] S_MEM_READ  = 4'd4;
   localparam logic [3:0] S_MEM_WB    = 4'd5;
   localparam logic [3:0] S_MEM_WRITE = 4'd6;
   localparam logic [3:0] S_R_EXEC    = 4'd7;
   localparam logic [3:0] S_R_WB      = 4'd8;
   localparam logic [3:0] S_BRANCH    = 4'd9;
   localparam logic [3:0] S_I_EXEC    = 4'd10;
   localparam logic [3:0] S_I_WB      = 4'd11;
   localparam logic [3:0] S_JUMP      = 4'd12;
   localparam logic [3:0] S_JR        = 4'd13;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_AND   = 3'b011;
   localparam logic [2:0] ALU_RTYPE = 3'b100;

   logic [3:0] state_q, state_d;
   logic [5:0] op_q, op_d;

   // State and latched-opcode registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= 6'd0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   // Opcode is captured only in DECODE so later IR changes cannot disturb execution.
   always_comb begin
      op_d = op_q;
      if (state_q == S_DECODE) begin
         op_d = bus.opcode;
      end else begin
         op_d = op_q;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = S_IDLE;
      case (state_q)
         S_IDLE:      state_d = S_FETCH;
         S_FETCH:     state_d = S_DECODE;
         S_DECODE: begin
            case (bus.opcode)
               OP_LW, OP_SW:     state_d = S_MEM_ADDR;
               OP_RTYPE:         state_d = S_R_EXEC;
               OP_BEQ:           state_d = S_BRANCH;
               OP_ADDI, OP_ANDI: state_d = S_I_EXEC;
               OP_J:             state_d = S_JUMP;
               default:          state_d = S_FETCH;
            endcase
         end
         S_MEM_ADDR: begin
            if (op_q == OP_LW) begin
               state_d = S_MEM_READ;
            end else begin
               state_d = S_MEM_WRITE;
            end
         end
         S_MEM_READ:  state_d = S_MEM_WB;
         S_MEM_WB:    state_d = S_FETCH;
         S_MEM_WRITE: state_d = S_FETCH;
         S_R_EXEC: begin
            // jreg is only meaningful here, while alu_op selects R-type decode.
            if (bus.jreg) begin
               state_d = S_JR;
            end else begin
               state_d = S_R_WB;
            end
         end
         S_R_WB:      state_d = S_FETCH;
         S_BRANCH:    state_d = S_FETCH;
         S_I_EXEC:    state_d = S_I_WB;
         S_I_WB:      state_d = S_FETCH;
         S_JUMP:      state_d = S_FETCH;
         S_JR:        state_d = S_FETCH;
         default:     state_d = S_IDLE;
      endcase
   end

   // Moore output decode; pc_en in BRANCH follows zero combinationally.
   always_comb begin
      bus.pc_en      = 1'b0;
      bus.pc_src     = 2'b00;
      bus.ir_write   = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.i_or_d     = 1'b0;
      bus.reg_write  = 1'b0;
      bus.reg_dst    = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.alu_src_a  = 1'b0;
      bus.alu_src_b  = 2'b00;
      bus.zero_ext   = 1'b0;
      bus.alu_op     = ALU_ADD;
      bus.done       = 1'b0;
      bus.illegal_op = 1'b0;
      case (state_q)
         S_FETCH: begin
            bus.mem_read  = 1'b1;
            bus.ir_write  = 1'b1;
            bus.alu_src_b = 2'b01;
            bus.pc_en     = 1'b1;
         end
         S_DECODE: begin
            bus.alu_src_b = 2'b11;
            case (bus.opcode)
               OP_LW, OP_SW, OP_RTYPE, OP_BEQ,
               OP_ADDI, OP_ANDI, OP_J: bus.illegal_op = 1'b0;
               default:                bus.illegal_op = 1'b1;
            endcase
         end
         S_MEM_ADDR: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b10;
         end
         S_MEM_READ: begin
            bus.mem_read = 1'b1;
            bus.i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            bus.reg_write  = 1'b1;
            bus.mem_to_reg = 1'b1;
            bus.done       = 1'b1;
         end
         S_MEM_WRITE: begin
            bus.mem_write = 1'b1;
            bus.i_or_d    = 1'b1;
            bus.done      = 1'b1;
         end
         S_R_EXEC: begin
            bus.alu_src_a = 1'b1;
            bus.alu_op    = ALU_RTYPE;
         end
         S_R_WB: begin
            bus.reg_write = 1'b1;
            bus.reg_dst   = 1'b1;
            bus.done      = 1'b1;
         end
         S_BRANCH: begin
            bus.alu_src_a = 1'b1;
            bus.alu_op    = ALU_SUB;
            bus.pc_src    = 2'b01;
            bus.pc_en     = bus.zero;
            bus.done      = 1'b1;
         end
         S_I_EXEC: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b10;
            if (op_q == OP_ANDI) begin
               bus.alu_op   = ALU_AND;
               bus.zero_ext = 1'b1;
            end else begin
               bus.alu_op   = ALU_ADD;
               bus.zero_ext = 1'b0;
            end
         end
         S_I_WB: begin
            bus.reg_write = 1'b1;
            bus.done      = 1'b1;
         end
         S_JUMP: begin
            bus.pc_src = 2'b10;
            bus.pc_en  = 1'b1;
            bus.done   = 1'b1;
         end
         S_JR: begin
            bus.pc_src = 2'b11;
            bus.pc_en  = 1'b1;
            bus.done   = 1'b1;
         end
         default: begin
            bus.pc_en = 1'b0;
         end
      endcase
   end

   // Debug view of the current state.
   always_comb begin
      bus.state = state_q;
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed plus randomized bench for multicycle_control against an
// instruction-level reference model (state sequence per opcode, outputs per step).
module tb_multicycle_control;

   typedef struct packed {
      logic       pc_en;
      logic [1:0] pc_src;
      logic       ir_write;
      logic       mem_read;
      logic       mem_write;
      logic       i_or_d;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       zero_ext;
      logic [2:0] alu_op;
      logic       done;
      logic       illegal_op;
   } outs_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   multicycle_control_if bus ();

   multicycle_control dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic outs_t observed();
      outs_t o;
      o.pc_en      = bus.pc_en;
      o.pc_src     = bus.pc_src;
      o.ir_write   = bus.ir_write;
      o.mem_read   = bus.mem_read;
      o.mem_write  = bus.mem_write;
      o.i_or_d     = bus.i_or_d;
      o.reg_write  = bus.reg_write;
      o.reg_dst    = bus.reg_dst;
      o.mem_to_reg = bus.mem_to_reg;
      o.alu_src_a  = bus.alu_src_a;
      o.alu_src_b  = bus.alu_src_b;
      o.zero_ext   = bus.zero_ext;
      o.alu_op     = bus.alu_op;
      o.done       = bus.done;
      o.illegal_op = bus.illegal_op;
      return o;
   endfunction

   // Expected control word for one step of an instruction, taken from the step table.
   function automatic outs_t expected(int st, logic [5:0] op, logic z);
      outs_t e;
      e = '0;
      case (st)
         1:  begin e.mem_read = 1'b1; e.ir_write = 1'b1; e.alu_src_b = 2'b01; e.pc_en = 1'b1; end
         2:  begin e.alu_src_b = 2'b11; e.illegal_op = !is_legal(op); end
         3:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
         4:  begin e.mem_read = 1'b1; e.i_or_d = 1'b1; end
         5:  begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.done = 1'b1; end
         6:  begin e.mem_write = 1'b1; e.i_or_d = 1'b1; e.done = 1'b1; end
         7:  begin e.alu_src_a = 1'b1; e.alu_op = 3'b100; end
         8:  begin e.reg_write = 1'b1; e.reg_dst = 1'b1; e.done = 1'b1; end
         9:  begin e.alu_src_a = 1'b1; e.alu_op = 3'b001; e.pc_src = 2'b01; e.pc_en = z; e.done = 1'b1; end
         10: begin
            e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
            e.alu_op    = (op == 6'b001100) ? 3'b011 : 3'b000;
            e.zero_ext  = (op == 6'b001100);
         end
         11: begin e.reg_write = 1'b1; e.done = 1'b1; end
         12: begin e.pc_src = 2'b10; e.pc_en = 1'b1; e.done = 1'b1; end
         13: begin e.pc_src = 2'b11; e.pc_en = 1'b1; e.done = 1'b1; end
         default: e = '0;
      endcase
      return e;
   endfunction

   function automatic bit is_legal(logic [5:0] op);
      return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                        6'b001000, 6'b001100, 6'b000010};
   endfunction

   task automatic check_state(string tag, logic [3:0] exp);
      n_cmp++;
      assert (bus.state === exp) else begin
         n_bad++;
         $error("FAIL %s state: got %0d expected %0d", tag, bus.state, exp);
      end
   endtask

   task automatic check_outs(string tag, outs_t exp);
      outs_t obs;
      obs = observed();
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s outputs: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Runs one instruction starting in FETCH (just after a clock edge); ends back in FETCH.
   task automatic run_instr(string tag, logic [5:0] op, logic z, logic jr);
      int seq[$];
      logic zi;
      case (op)
         6'b100011: seq = '{1, 2, 3, 4, 5};
         6'b101011: seq = '{1, 2, 3, 6};
         6'b000000: seq = jr ? '{1, 2, 7, 13} : '{1, 2, 7, 8};
         6'b000100: seq = '{1, 2, 9};
         6'b001000, 6'b001100: seq = '{1, 2, 10, 11};
         6'b000010: seq = '{1, 2, 12};
         default:   seq = '{1, 2};
      endcase
      foreach (seq[k]) begin
         zi = (seq[k] == 9) ? z : 1'($urandom_range(1));
         bus.zero   = zi;
         bus.jreg   = (seq[k] == 7) ? jr : 1'($urandom_range(1));
         bus.opcode = (seq[k] <= 2) ? op : 6'($urandom_range(63));
         #1;
         check_state(tag, 4'(seq[k]));
         check_outs(tag, expected(seq[k], op, zi));
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [5:0] rop;
      n_cmp      = 0;
      n_bad      = 0;
      rst        = 1'b1;
      bus.opcode = 6'd0;
      bus.zero   = 1'b0;
      bus.jreg   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_state("reset", 4'd0);
      check_outs("reset", '0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_instr("lw", 6'b100011, 1'b0, 1'b0);
      run_instr("sw", 6'b101011, 1'b0, 1'b0);
      run_instr("rtype", 6'b000000, 1'b0, 1'b0);
      run_instr("jr", 6'b000000, 1'b0, 1'b1);
      run_instr("beq_taken", 6'b000100, 1'b1, 1'b0);
      run_instr("beq_not", 6'b000100, 1'b0, 1'b0);
      run_instr("andi", 6'b001100, 1'b0, 1'b0);
      run_instr("addi", 6'b001000, 1'b0, 1'b0);
      run_instr("j", 6'b000010, 1'b0, 1'b0);
      run_instr("illegal", 6'b111111, 1'b0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(8))
            0: rop = 6'b100011;
            1: rop = 6'b101011;
            2: rop = 6'b000000;
            3: rop = 6'b000100;
            4: rop = 6'b001000;
            5: rop = 6'b001100;
            6: rop = 6'b000010;
            default: rop = 6'($urandom_range(63));
         endcase
         run_instr("random", rop, 1'($urandom_range(1)), 1'($urandom_range(1)));
      end

      // Reset during MEM_READ of an lw.
      bus.opcode = 6'b100011;
      repeat (3) @(posedge clk);
      #1;
      check_state("mid_lw", 4'd4);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_state("mid_reset", 4'd0);
      check_outs("mid_reset", '0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      run_instr("after_reset", 6'b101011, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
